// File: rtl/weight_load_ctrl_if.sv
// weight_load_ctrl_if: stream-in handshake plus weight-buffer write port of weight_load_ctrl
interface weight_load_ctrl_if #(
  parameter int WEIGHT_ADDR_COL = 3,
  parameter int WEIGHT_ADDR_ROW = 5,
  parameter int DATA_WIDTH      = 8
);
  logic                       load_start;
  logic                       in_valid;
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       in_ready;
  logic                       weight_write_en;
  logic [WEIGHT_ADDR_ROW-1:0] weight_wr_row;
  logic [WEIGHT_ADDR_COL-1:0] weight_wr_col;
  logic [DATA_WIDTH-1:0]      weight_wr_data;
  logic                       load_busy;
  logic                       load_done;
  logic                       weight_valid;
  modport master (
    output load_start, in_valid, in_data,
    input  in_ready, weight_write_en, weight_wr_row, weight_wr_col, weight_wr_data,
           load_busy, load_done, weight_valid
  );
  modport slave (
    input  load_start, in_valid, in_data,
    output in_ready, weight_write_en, weight_wr_row, weight_wr_col, weight_wr_data,
           load_busy, load_done, weight_valid
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: turns a valid/ready weight stream into row-major weight-buffer writes
module weight_load_ctrl #(
  parameter int WEIGHT_SIZE_COL = 7,
  parameter int WEIGHT_SIZE_ROW = 28,
  parameter int WEIGHT_ADDR_COL = 3,
  parameter int WEIGHT_ADDR_ROW = 5,
  parameter int DATA_WIDTH      = 8
) (
  input logic               clk,
  input logic               reset,
  weight_load_ctrl_if.slave bus
);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t                     r_state, w_next;
  logic [WEIGHT_ADDR_ROW-1:0] r_row, r_wr_row;
  logic [WEIGHT_ADDR_COL-1:0] r_col, r_wr_col;
  logic [DATA_WIDTH-1:0]      r_wr_data;
  logic                       r_we, r_done, r_valid;
  logic                       w_start, w_accept, w_last_col, w_last;
  always_comb begin
    w_start    = (r_state == IDLE) & bus.load_start;
    w_accept   = (r_state == LOAD) & bus.in_valid;
    w_last_col = r_col == WEIGHT_ADDR_COL'(WEIGHT_SIZE_COL - 1);
    w_last     = w_accept & w_last_col & (r_row == WEIGHT_ADDR_ROW'(WEIGHT_SIZE_ROW - 1));
    w_next     = w_start ? LOAD : w_last ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row     <= '0;
      r_col     <= '0;
      r_we      <= 1'b0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_we   <= w_accept;
      r_done <= w_last;
      if (w_accept) begin
        r_wr_row  <= r_row;
        r_wr_col  <= r_col;
        r_wr_data <= bus.in_data;
      end
      if (w_start || w_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_accept) begin
        r_col <= w_last_col ? '0 : r_col + WEIGHT_ADDR_COL'(1);
        r_row <= w_last_col ? r_row + WEIGHT_ADDR_ROW'(1) : r_row;
      end
      if (w_last) r_valid <= 1'b1;
      else if (w_start) r_valid <= 1'b0;
    end
  end
  assign bus.in_ready        = r_state == LOAD;
  assign bus.load_busy       = r_state == LOAD;
  assign bus.weight_write_en = r_we;
  assign bus.weight_wr_row   = r_wr_row;
  assign bus.weight_wr_col   = r_wr_col;
  assign bus.weight_wr_data  = r_wr_data;
  assign bus.load_done       = r_done;
  assign bus.weight_valid    = r_valid;
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: directed loads with a write scoreboard for weight_load_ctrl
module tb_weight_load_ctrl;
  localparam int COL = 7, ROW = 28, AC = 3, AR = 5, DW = 8, N = COL * ROW;
  typedef struct packed {
    logic [AR-1:0] row;
    logic [AC-1:0] col;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0, n_err = 0, n_done = 0, idx = 0;
  exp_t q[$];
  exp_t e;
  weight_load_ctrl_if #(.WEIGHT_ADDR_COL(AC), .WEIGHT_ADDR_ROW(AR), .DATA_WIDTH(DW)) bus ();
  weight_load_ctrl #(
    .WEIGHT_SIZE_COL(COL), .WEIGHT_SIZE_ROW(ROW),
    .WEIGHT_ADDR_COL(AC), .WEIGHT_ADDR_ROW(AR), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic gap(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic word(input logic ls);
    bus.in_valid   = 1'b1;
    bus.in_data    = DW'(idx);
    bus.load_start = ls;
    q.push_back('{row: AR'(idx / COL), col: AC'(idx % COL), data: DW'(idx), last: (idx == N - 1)});
    idx = (idx == N - 1) ? 0 : idx + 1;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.load_start = 1'b0;
  endtask
  task automatic words(input int k);
    repeat (k) word(1'b0);
  endtask
  task automatic start();
    bus.load_start = 1'b1;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
    idx = 0;
    check("ready_in_load", bus.in_ready, 1);
    check("busy_in_load", bus.load_busy, 1);
    check("valid_cleared", bus.weight_valid, 0);
  endtask
  task automatic idle_outputs(input string tag);
    check({tag, "_we"}, bus.weight_write_en, 0);
    check({tag, "_row"}, bus.weight_wr_row, 0);
    check({tag, "_col"}, bus.weight_wr_col, 0);
    check({tag, "_data"}, bus.weight_wr_data, 0);
    check({tag, "_done"}, bus.load_done, 0);
    check({tag, "_valid"}, bus.weight_valid, 0);
    check({tag, "_ready"}, bus.in_ready, 0);
    check({tag, "_busy"}, bus.load_busy, 0);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.load_done) n_done++;
      if (bus.weight_write_en) begin
        check("write_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("wr_row_col_data", {bus.weight_wr_row, bus.weight_wr_col, bus.weight_wr_data},
                {e.row, e.col, e.data});
          check("done_pulse", bus.load_done, e.last);
          check("valid_flag", bus.weight_valid, e.last);
        end
      end else check("no_done_without_write", bus.load_done, 0);
    end
  end
  initial begin
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    gap(2);
    idle_outputs("reset_state");
    reset = 1'b0;
    gap(1);
    start();
    words(N);
    check("ready_after_final", bus.in_ready, 0);
    check("busy_after_final", bus.load_busy, 0);
    check("valid_after_final", bus.weight_valid, 1);
    gap(1);
    check("done_count_t1", n_done, 1);
    check("queue_empty_t1", q.size(), 0);
    start();
    words(7);
    gap(3);
    words(94);
    gap(3);
    words(N - 101);
    gap(1);
    check("done_count_t2", n_done, 2);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (5) begin
      check("ready_in_idle", bus.in_ready, 0);
      gap(1);
    end
    bus.in_valid = 1'b0;
    start();
    words(N);
    gap(1);
    check("done_count_t3", n_done, 3);
    start();
    words(50);
    word(1'b1);
    check("busy_after_restart_try", bus.load_busy, 1);
    words(N - 51);
    gap(1);
    check("valid_held", bus.weight_valid, 1);
    gap(2);
    check("valid_still_held", bus.weight_valid, 1);
    start();
    words(N);
    gap(1);
    check("done_count_t4", n_done, 5);
    start();
    words(121);
    gap(1);
    check("queue_empty_before_reset", q.size(), 0);
    reset = 1'b1;
    #1;
    idle_outputs("mid_load_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    gap(2);
    check("done_count_after_reset", n_done, 5);
    check("ready_after_reset", bus.in_ready, 0);
    start();
    words(N);
    gap(1);
    check("done_count_t5", n_done, 6);
    start();
    words(N - 1);
    word(1'b1);
    check("ready_after_final_with_start", bus.in_ready, 0);
    check("busy_after_final_with_start", bus.load_busy, 0);
    gap(1);
    check("ready_stays_idle", bus.in_ready, 0);
    check("valid_after_t6", bus.weight_valid, 1);
    gap(2);
    check("done_count_t6", n_done, 7);
    check("queue_empty_end", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
